// File: rtl/img_sub_sched.sv
// Round-robin scheduler sharing one image-subtraction engine between two show-ahead pixel sources.
// Each job feeds 2*PIX pixels (image A then image B), then collects PIX owner-tagged diffs or times out.
module img_sub_sched #(
   parameter int DW     = 4,
   parameter int PIX    = 9,
   parameter int TO_CYC = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          src0_req,
   input  logic [DW-1:0] src0_data,
   output logic          src0_ack,
   input  logic          src1_req,
   input  logic [DW-1:0] src1_data,
   output logic          src1_ack,
   output logic          eng_in_valid,
   output logic [DW-1:0] eng_in_image,
   input  logic          eng_out_valid,
   input  logic [DW-1:0] eng_out_diff,
   output logic          res_valid,
   output logic [DW-1:0] res_diff,
   output logic          res_owner,
   output logic          res_last,
   output logic          busy,
   output logic          err_timeout,
   output logic [1:0]    dbg_state
);

   localparam int CNT_W = $clog2(2 * PIX);
   localparam int TMR_W = $clog2(TO_CYC);
   localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(2 * PIX - 1);
   localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(PIX - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TO_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FEED    = 2'd1,
      S_COLLECT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             eng_in_valid_q, eng_in_valid_d;
   logic [DW-1:0]    eng_in_image_q, eng_in_image_d;
   logic             res_valid_q, res_valid_d;
   logic [DW-1:0]    res_diff_q, res_diff_d;
   logic             res_owner_q, res_owner_d;
   logic             res_last_q, res_last_d;
   logic             err_timeout_q, err_timeout_d;
   logic             grant;

   // Handshake: srcN_req means a whole job is queued; srcN_ack is a pop strobe, so the head
   // pixel is consumed on every rising edge where ack is high (no back-pressure from the engine).
   assign src0_ack     = (state_q == S_FEED) && !owner_q;
   assign src1_ack     = (state_q == S_FEED) && owner_q;
   assign busy         = (state_q != S_IDLE);
   assign dbg_state    = state_q;
   assign eng_in_valid = eng_in_valid_q;
   assign eng_in_image = eng_in_image_q;
   assign res_valid    = res_valid_q;
   assign res_diff     = res_diff_q;
   assign res_owner    = res_owner_q;
   assign res_last     = res_last_q;
   assign err_timeout  = err_timeout_q;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_owner_d   = last_owner_q;
      cnt_d          = cnt_q;
      tmr_d          = tmr_q;
      eng_in_valid_d = 1'b0;
      eng_in_image_d = '0;
      res_valid_d    = 1'b0;
      res_diff_d     = res_diff_q;
      res_owner_d    = res_owner_q;
      res_last_d     = 1'b0;
      err_timeout_d  = 1'b0;
      grant          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (src0_req || src1_req) begin
               grant        = (src0_req && src1_req) ? !last_owner_q : src1_req;
               owner_d      = grant;
               last_owner_d = grant;
               cnt_d        = '0;
               state_d      = S_FEED;
            end
         end
         S_FEED: begin
            eng_in_valid_d = 1'b1;
            eng_in_image_d = owner_q ? src1_data : src0_data;
            if (cnt_q == FEED_LAST) begin
               cnt_d   = '0;
               tmr_d   = '0;
               state_d = S_COLLECT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_COLLECT: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (eng_out_valid) begin
               res_valid_d = 1'b1;
               res_diff_d  = eng_out_diff;
               res_owner_d = owner_q;
               cnt_d       = cnt_q + CNT_W'(1);
            end
            // The final result beats a simultaneous timer expiry.
            if (eng_out_valid && (cnt_q == COL_LAST)) begin
               res_last_d = 1'b1;
               state_d    = S_IDLE;
            end else if (tmr_q == TMR_LAST) begin
               err_timeout_d = 1'b1;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         owner_q        <= 1'b0;
         last_owner_q   <= 1'b1;
         cnt_q          <= '0;
         tmr_q          <= '0;
         eng_in_valid_q <= 1'b0;
         eng_in_image_q <= '0;
         res_valid_q    <= 1'b0;
         res_diff_q     <= '0;
         res_owner_q    <= 1'b0;
         res_last_q     <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_owner_q   <= last_owner_d;
         cnt_q          <= cnt_d;
         tmr_q          <= tmr_d;
         eng_in_valid_q <= eng_in_valid_d;
         eng_in_image_q <= eng_in_image_d;
         res_valid_q    <= res_valid_d;
         res_diff_q     <= res_diff_d;
         res_owner_q    <= res_owner_d;
         res_last_q     <= res_last_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

endmodule

// File: tb/tb_img_sub_sched.sv
// Directed bench for img_sub_sched: show-ahead source model, scripted engine responses,
// per-scenario tasks with inline checks against hand-derived expectations.
module tb_img_sub_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       src0_req, src0_ack, src1_req, src1_ack;
   logic [3:0] src0_data, src1_data;
   logic       eng_in_valid, eng_out_valid;
   logic [3:0] eng_in_image, eng_out_diff;
   logic       res_valid, res_owner, res_last, busy, err_timeout;
   logic [3:0] res_diff;
   logic [1:0] dbg_state;

   logic [3:0] src0_mem[18];
   logic [3:0] src1_mem[18];
   int ptr0, ptr1;
   int n_vec, n_err;

   img_sub_sched #(.DW(4), .PIX(9), .TO_CYC(32)) dut (
      .clk(clk), .rst(rst),
      .src0_req(src0_req), .src0_data(src0_data), .src0_ack(src0_ack),
      .src1_req(src1_req), .src1_data(src1_data), .src1_ack(src1_ack),
      .eng_in_valid(eng_in_valid), .eng_in_image(eng_in_image),
      .eng_out_valid(eng_out_valid), .eng_out_diff(eng_out_diff),
      .res_valid(res_valid), .res_diff(res_diff), .res_owner(res_owner), .res_last(res_last),
      .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // One clock: pops the show-ahead sources on acks seen before the edge, samples 1 ns after it.
   task automatic tick();
      logic a0, a1;
      a0 = src0_ack;
      a1 = src1_ack;
      @(posedge clk);
      #1;
      if (a0 === 1'b1) ptr0 = (ptr0 + 1) % 18;
      if (a1 === 1'b1) ptr1 = (ptr1 + 1) % 18;
      src0_data = src0_mem[ptr0];
      src1_data = src1_mem[ptr1];
   endtask

   task automatic realign();
      ptr0 = 0;
      ptr1 = 0;
      src0_data = src0_mem[0];
      src1_data = src1_mem[0];
   endtask

   // Starts in the IDLE arbitration cycle, ends in the first COLLECT cycle.
   task automatic feed_job(input int own, input bit stray);
      int p;
      logic [3:0] e_img;
      logic [1:0] e_ack;
      eng_out_valid = stray;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL feed_idle_busy: got %b exp 0", busy); end
      tick();
      p = own ? ptr1 : ptr0;
      e_ack = own ? 2'b10 : 2'b01;
      for (int i = 0; i < 18; i++) begin
         n_vec++; if ({src1_ack, src0_ack} !== e_ack) begin n_err++; $display("FAIL feed_ack cyc %0d: got %b exp %b", i, {src1_ack, src0_ack}, e_ack); end
         n_vec++; if (eng_in_valid !== (i != 0)) begin n_err++; $display("FAIL feed_in_valid cyc %0d: got %b exp %b", i, eng_in_valid, (i != 0)); end
         if (i != 0) begin
            e_img = own ? src1_mem[(p + i - 1) % 18] : src0_mem[(p + i - 1) % 18];
            n_vec++; if (eng_in_image !== e_img) begin n_err++; $display("FAIL feed_image cyc %0d: got %h exp %h", i, eng_in_image, e_img); end
         end
         if (stray) begin
            n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stray_res_valid cyc %0d: got %b exp 0", i, res_valid); end
         end
         tick();
      end
      eng_out_valid = 1'b0;
      e_img = own ? src1_mem[(p + 17) % 18] : src0_mem[(p + 17) % 18];
      n_vec++; if ({eng_in_valid, eng_in_image} !== {1'b1, e_img}) begin n_err++; $display("FAIL feed_tail: got %b/%h exp 1/%h", eng_in_valid, eng_in_image, e_img); end
      n_vec++; if ({src1_ack, src0_ack} !== 2'b00) begin n_err++; $display("FAIL feed_ack_after: got %b exp 00", {src1_ack, src0_ack}); end
   endtask

   // Starts in the first COLLECT cycle; the engine answers after lat idle cycles.
   task automatic collect_job(input int own, input int lat, input int base, input int step);
      logic [3:0] e_d;
      for (int j = 0; j < lat; j++) begin
         tick();
         n_vec++; if ({res_valid, busy} !== 2'b01) begin n_err++; $display("FAIL collect_wait: got valid/busy %b exp 01", {res_valid, busy}); end
      end
      for (int k = 0; k < 9; k++) begin
         e_d = 4'((base + step * k) % 16);
         eng_out_valid = 1'b1;
         eng_out_diff = e_d;
         tick();
         eng_out_valid = 1'b0;
         n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL res_valid k%0d: got %b exp 1", k, res_valid); end
         n_vec++; if (res_diff !== e_d) begin n_err++; $display("FAIL res_diff k%0d: got %h exp %h", k, res_diff, e_d); end
         n_vec++; if (res_owner !== 1'(own)) begin n_err++; $display("FAIL res_owner k%0d: got %b exp %0d", k, res_owner, own); end
         n_vec++; if (res_last !== (k == 8)) begin n_err++; $display("FAIL res_last k%0d: got %b exp %b", k, res_last, (k == 8)); end
         n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL collect_err k%0d: got %b exp 0", k, err_timeout); end
      end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL collect_end_busy: got %b exp 0", busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      src0_req = 1'b0;
      src1_req = 1'b0;
      eng_out_valid = 1'b0;
      eng_out_diff = 4'h0;
      realign();
      repeat (3) tick();
      n_vec++; if ({src0_ack, src1_ack, eng_in_valid, eng_in_image, res_valid, res_diff, res_owner, res_last, busy, err_timeout} !== 16'h0) begin
         n_err++; $display("FAIL reset_outputs: got %h exp 0000", {src0_ack, src1_ack, eng_in_valid, eng_in_image, res_valid, res_diff, res_owner, res_last, busy, err_timeout});
      end
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
      rst = 1'b0;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
   endtask

   task automatic test_single();
      src0_req = 1'b1;
      feed_job(0, 1'b0);
      src0_req = 1'b0;
      collect_job(0, 0, 1, 0);
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_no_regrant: got %b exp 0", busy); end
   endtask

   task automatic test_stray();
      eng_out_valid = 1'b1;
      eng_out_diff = 4'h5;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++; if ({res_valid, busy} !== 2'b00) begin n_err++; $display("FAIL stray_idle: got valid/busy %b exp 00", {res_valid, busy}); end
      end
      src0_req = 1'b1;
      feed_job(0, 1'b1);
      src0_req = 1'b0;
      collect_job(0, 2, 7, 3);
   endtask

   task automatic test_timeout();
      src0_req = 1'b1;
      feed_job(0, 1'b0);
      src0_req = 1'b0;
      for (int j = 0; j < 32; j++) begin
         tick();
         n_vec++; if (err_timeout !== (j == 31)) begin n_err++; $display("FAIL timeout_pulse c%0d: got %b exp %b", j + 1, err_timeout, (j == 31)); end
      end
      n_vec++; if ({busy, res_valid, res_last} !== 3'b000) begin n_err++; $display("FAIL timeout_abort: got busy/valid/last %b exp 000", {busy, res_valid, res_last}); end
      tick();
      n_vec++; if ({err_timeout, busy} !== 2'b00) begin n_err++; $display("FAIL timeout_after: got err/busy %b exp 00", {err_timeout, busy}); end
   endtask

   task automatic test_last_at_timeout();
      src0_req = 1'b1;
      feed_job(0, 1'b0);
      src0_req = 1'b0;
      for (int j = 0; j < 32; j++) begin
         eng_out_valid = (j < 8) || (j == 31);
         eng_out_diff = 4'(j);
         tick();
         n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL race_err c%0d: got %b exp 0", j + 1, err_timeout); end
         if (j == 7) begin
            n_vec++; if ({res_valid, res_last} !== 2'b10) begin n_err++; $display("FAIL race_eighth: got valid/last %b exp 10", {res_valid, res_last}); end
         end
      end
      eng_out_valid = 1'b0;
      n_vec++; if ({res_valid, res_last, res_diff, busy} !== 7'b11_1111_0) begin n_err++; $display("FAIL race_last: got valid/last/diff/busy %b exp 1111110", {res_valid, res_last, res_diff, busy}); end
      tick();
      n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL race_err_after: got %b exp 0", err_timeout); end
   endtask

   task automatic test_reset_mid_feed();
      src0_req = 1'b1;
      tick();
      src0_req = 1'b0;
      repeat (5) tick();
      n_vec++; if ({src0_ack, eng_in_valid} !== 2'b11) begin n_err++; $display("FAIL midfeed_active: got ack/valid %b exp 11", {src0_ack, eng_in_valid}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if ({src0_ack, src1_ack, eng_in_valid, eng_in_image, res_valid, res_diff, res_owner, res_last, busy, err_timeout} !== 16'h0) begin
         n_err++; $display("FAIL midfeed_outputs: got %h exp 0000", {src0_ack, src1_ack, eng_in_valid, eng_in_image, res_valid, res_diff, res_owner, res_last, busy, err_timeout});
      end
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL midfeed_state: got %0d exp 0", dbg_state); end
      realign();
      tick();
      n_vec++; if ({busy, eng_in_valid} !== 2'b00) begin n_err++; $display("FAIL midfeed_stay_idle: got busy/valid %b exp 00", {busy, eng_in_valid}); end
   endtask

   // Runs right after the mid-feed reset, so the first dual grant must go to source 0.
   task automatic test_back_to_back();
      src0_req = 1'b1;
      src1_req = 1'b1;
      for (int g = 0; g < 4; g++) begin
         feed_job(g % 2, 1'b0);
         collect_job(g % 2, (g * 2 + 1) % 4, (g % 2) * 5 + 2, 1);
      end
      src0_req = 1'b0;
      src1_req = 1'b0;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_final_idle: got %b exp 0", busy); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 18; i++) begin
         src0_mem[i] = 4'((i < 9) ? i + 1 : i - 9);
         src1_mem[i] = 4'((i * 7 + 3) % 16);
      end
      test_reset();
      test_single();
      test_stray();
      test_timeout();
      test_last_at_timeout();
      test_reset_mid_feed();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
